// File: rtl/sav_pkg.sv
// sav_pkg: shared types and constants for the cart-RAM backup sector server.
//   sav_state_t  : transfer FSM states
//   SECTOR_WORDS : 16-bit words per 512-byte sector
//   FILL_WORD    : value returned for loads of out-of-range sectors
//   LAST_WORD    : terminal value of the 8-bit word counter
package sav_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_ADDR,
    WR_CAP,
    WR_REQ,
    DONE
  } sav_state_t;

  localparam int unsigned SECTOR_WORDS = 256;
  localparam logic [15:0] FILL_WORD    = 16'hFFFF;
  localparam logic [7:0]  LAST_WORD    = 8'(SECTOR_WORDS - 1);

endpackage

// File: rtl/sav_sector_server.sv
// sav_sector_server: responder for the sd_lba/sd_rd/sd_wr/sd_ack sector protocol.
// Moves one 256-word sector between the initiator buffer port and a word-wide
// backing store holding the .sav image.
// Ports:
//   clk_sys, reset_n          clock, async active-low reset
//   sd_lba, sd_rd, sd_wr      sector request (sampled only in IDLE; sd_rd wins ties)
//   sd_ack                    high for the whole transfer
//   sd_buff_addr/dout/wr/din  initiator buffer port (din valid 1 cycle after addr)
//   st_addr/rd/wr/wdata       store command, held until st_ready
//   st_ready, st_rdata, st_valid  store handshake / read return
//   oob                       1-cycle pulse when the accepted LBA is out of range
module sav_sector_server
  import sav_pkg::*;
#(
  parameter int unsigned LBA_W    = 32,
  parameter int unsigned SECT_AW  = 9,
  parameter int unsigned STORE_AW = 17
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [LBA_W-1:0]    sd_lba,
  input  logic                sd_rd,
  input  logic                sd_wr,
  output logic                sd_ack,
  output logic [7:0]          sd_buff_addr,
  output logic [15:0]         sd_buff_dout,
  output logic                sd_buff_wr,
  input  logic [15:0]         sd_buff_din,
  output logic [STORE_AW-1:0] st_addr,
  output logic                st_rd,
  output logic                st_wr,
  output logic [15:0]         st_wdata,
  input  logic                st_ready,
  input  logic [15:0]         st_rdata,
  input  logic                st_valid,
  output logic                oob
);

  sav_state_t         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [SECT_AW-1:0] lba_q, lba_d;
  logic               oor_q, oor_d;
  logic               oob_q, oob_d;
  logic [7:0]         baddr_q, baddr_d;
  logic [15:0]        bdout_q, bdout_d;
  logic               bwr_q, bwr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               lba_oor;

  assign lba_oor = (sd_lba >> SECT_AW) != '0;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lba_q   <= '0;
      oor_q   <= 1'b0;
      oob_q   <= 1'b0;
      baddr_q <= '0;
      bdout_q <= '0;
      bwr_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lba_q   <= lba_d;
      oor_q   <= oor_d;
      oob_q   <= oob_d;
      baddr_q <= baddr_d;
      bdout_q <= bdout_d;
      bwr_q   <= bwr_d;
      wdata_q <= wdata_d;
    end
  end

  // Out-of-range sectors run the same state walk as real ones but skip the
  // store handshakes, so the initiator sees identical pacing and addressing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lba_d   = lba_q;
    oor_d   = oor_q;
    oob_d   = 1'b0;
    baddr_d = baddr_q;
    bdout_d = bdout_q;
    bwr_d   = 1'b0;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (sd_rd || sd_wr) begin
          lba_d   = sd_lba[SECT_AW-1:0];
          oor_d   = lba_oor;
          oob_d   = lba_oor;
          cnt_d   = '0;
          baddr_d = '0;
          state_d = sd_rd ? RD_REQ : WR_ADDR;
        end
      end
      RD_REQ: begin
        if (oor_q || st_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (oor_q || st_valid) begin
          bwr_d   = 1'b1;
          baddr_d = cnt_q;
          bdout_d = oor_q ? FILL_WORD : st_rdata;
          if (cnt_q == LAST_WORD) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = RD_REQ;
          end
        end
      end
      WR_ADDR: state_d = WR_CAP;
      WR_CAP: begin
        wdata_d = sd_buff_din;
        state_d = WR_REQ;
      end
      WR_REQ: begin
        if (oor_q || st_ready) begin
          if (cnt_q == LAST_WORD) begin
            state_d = DONE;
          end else begin
            // buffer address is registered, so it advances together with the
            // counter and is already valid during the next WR_ADDR cycle
            cnt_d   = cnt_q + 8'd1;
            baddr_d = cnt_q + 8'd1;
            state_d = WR_ADDR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sd_ack       = (state_q != IDLE) && (state_q != DONE);
  assign st_rd        = (state_q == RD_REQ) && !oor_q;
  assign st_wr        = (state_q == WR_REQ) && !oor_q;
  assign st_addr      = {lba_q, cnt_q};
  assign st_wdata     = wdata_q;
  assign sd_buff_addr = baddr_q;
  assign sd_buff_dout = bdout_q;
  assign sd_buff_wr   = bwr_q;
  assign oob          = oob_q;

endmodule

// File: tb/tb_sav_sector_server.sv
// tb_sav_sector_server: scoreboard bench for sav_sector_server.
// Stimulus pushes expected buffer strobes / store writes into queues; the
// monitor and store model pop and compare as the DUT produces them.
module tb_sav_sector_server;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout, sd_buff_din;
  logic        sd_buff_wr;
  logic [16:0] st_addr;
  logic        st_rd, st_wr, st_ready, st_valid;
  logic [15:0] st_wdata, st_rdata;
  logic        oob;

  always #5 clk_sys = ~clk_sys;

  sav_sector_server #(.LBA_W(32), .SECT_AW(9), .STORE_AW(17)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .st_addr(st_addr), .st_rd(st_rd),
    .st_wr(st_wr), .st_wdata(st_wdata), .st_ready(st_ready), .st_rdata(st_rdata),
    .st_valid(st_valid), .oob(oob)
  );

  typedef struct packed {
    logic [16:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        q_buf[$];
  exp_t        q_st[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_st_rd = 0, n_wr_acc = 0, n_oob = 0, n_strobe = 0;
  int          max_stall = 0;
  logic [15:0] smem [0:131071];
  logic [15:0] ibuf [0:255];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: buffer strobes, oob pulses, command exclusivity.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (reset_n) begin
        if (sd_buff_wr) begin
          n_strobe++;
          if (q_buf.size() == 0) begin
            n_err++;
            $display("FAIL buff_strobe: unexpected strobe addr %0h dout %0h", sd_buff_addr, sd_buff_dout);
          end else begin
            e = q_buf.pop_front();
            chk("buff_addr", 64'(sd_buff_addr), 64'(e.addr));
            chk("buff_dout", 64'(sd_buff_dout), 64'(e.data));
          end
        end
        if (oob) n_oob++;
        if (st_rd && st_wr) begin
          n_err++;
          $display("FAIL st_excl: st_rd and st_wr both high, got 1 expected 0");
        end
      end
    end
  end

  // Store model: random ready stalls, 1-cycle read latency, write scoreboard.
  initial begin : store_model
    exp_t        e;
    logic        pend_valid;
    logic [15:0] pend_data;
    int          stall;
    logic        held;
    logic [16:0] held_addr;
    logic [15:0] held_data;
    pend_valid = 1'b0; held = 1'b0; stall = 0;
    pend_data = '0; held_addr = '0; held_data = '0;
    st_ready = 1'b0; st_valid = 1'b0; st_rdata = '0;
    forever begin
      @(negedge clk_sys);
      st_ready = 1'b0;
      st_valid = 1'b0;
      if (!reset_n) begin
        pend_valid = 1'b0;
        held = 1'b0;
        stall = 0;
      end else begin
        if (pend_valid) begin
          st_valid = 1'b1;
          st_rdata = pend_data;
          pend_valid = 1'b0;
        end
        if (held) begin
          if (!st_wr) begin
            n_err++;
            $display("FAIL st_wr_hold: st_wr dropped during stall, got 0 expected 1");
          end else begin
            chk("st_addr_hold", 64'(st_addr), 64'(held_addr));
            chk("st_wdata_hold", 64'(st_wdata), 64'(held_data));
          end
          held = 1'b0;
        end
        if (st_rd || st_wr) begin
          if (stall > 0) begin
            stall--;
            if (st_wr) begin
              held = 1'b1;
              held_addr = st_addr;
              held_data = st_wdata;
            end
          end else begin
            st_ready = 1'b1;
            if (st_rd) begin
              n_st_rd++;
              pend_valid = 1'b1;
              pend_data = smem[st_addr];
            end else begin
              n_wr_acc++;
              smem[st_addr] = st_wdata;
              if (q_st.size() == 0) begin
                n_err++;
                $display("FAIL st_write: unexpected write addr %0h data %0h", st_addr, st_wdata);
              end else begin
                e = q_st.pop_front();
                chk("st_wr_addr", 64'(st_addr), 64'(e.addr));
                chk("st_wr_data", 64'(st_wdata), 64'(e.data));
              end
            end
            stall = $urandom_range(0, max_stall);
          end
        end
      end
    end
  end

  // Initiator buffer: registered read, data follows the address by one cycle.
  initial begin : ibuf_model
    logic [7:0] prev_a;
    prev_a = '0;
    sd_buff_din = '0;
    forever begin
      @(negedge clk_sys);
      sd_buff_din = ibuf[prev_a];
      prev_a = sd_buff_addr;
    end
  end

  task automatic push_load(input int sect, input logic [15:0] base);
    for (int k = 0; k < 256; k++) q_buf.push_back('{addr: 17'(k), data: base + 16'(k)});
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, {sd_ack, st_rd, st_wr, sd_buff_wr, oob, sd_buff_addr, sd_buff_dout, st_addr, st_wdata},
        64'd0);
  endtask

  task automatic wait_ack(input logic level, input int budget, input string name);
    int i;
    i = 0;
    while (sd_ack !== level && i < budget) begin
      @(negedge clk_sys);
      i++;
    end
    chk(name, 64'(sd_ack), 64'(level));
  endtask

  task automatic do_xfer(input logic rd, input logic wr, input logic [31:0] lba);
    @(negedge clk_sys);
    sd_rd = rd; sd_wr = wr; sd_lba = lba;
    wait_ack(1'b1, 50, "ack_rise");
    sd_rd = 1'b0; sd_wr = 1'b0;
    wait_ack(1'b0, 5000, "ack_fall");
    repeat (2) @(negedge clk_sys);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin : stim
    int s_rd, s_wr, s_oob, s_str, bad, low, i;
    reset_n = 1'b0; sd_rd = 1'b0; sd_wr = 1'b0; sd_lba = '0;
    for (int s = 0; s < 6; s++)
      for (int k = 0; k < 256; k++) smem[s*256 + k] = 16'h0000;
    for (int k = 0; k < 256; k++) ibuf[k] = ~16'(k);
    repeat (3) @(negedge clk_sys);
    chk_outputs_zero("reset_outputs");
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Load lba 3, no stalls
    max_stall = 0;
    for (int k = 0; k < 256; k++) smem[3*256 + k] = 16'h0300 + 16'(k);
    push_load(3, 16'h0300);
    s_wr = n_wr_acc; s_str = n_strobe; s_oob = n_oob;
    do_xfer(1'b1, 1'b0, 32'd3);
    chk("load3_queue_left", 64'(q_buf.size()), 64'd0);
    chk("load3_strobes", 64'(n_strobe - s_str), 64'd256);
    chk("load3_st_wr", 64'(n_wr_acc - s_wr), 64'd0);
    chk("load3_oob", 64'(n_oob - s_oob), 64'd0);

    // Save lba 0 with random stalls
    max_stall = 5;
    for (int k = 0; k < 256; k++) q_st.push_back('{addr: 17'(k), data: ~16'(k)});
    s_wr = n_wr_acc;
    do_xfer(1'b0, 1'b1, 32'd0);
    chk("save0_queue_left", 64'(q_st.size()), 64'd0);
    chk("save0_st_wr", 64'(n_wr_acc - s_wr), 64'd256);
    bad = 0;
    for (int k = 0; k < 256; k++) if (smem[k] !== ~16'(k)) bad++;
    chk("save0_store_words_bad", 64'(bad), 64'd0);

    // sd_rd and sd_wr together: load wins
    max_stall = 2;
    for (int k = 0; k < 256; k++) smem[256 + k] = 16'h0100 + 16'(k);
    push_load(1, 16'h0100);
    s_wr = n_wr_acc; s_str = n_strobe;
    do_xfer(1'b1, 1'b1, 32'd1);
    chk("both_queue_left", 64'(q_buf.size()), 64'd0);
    chk("both_strobes", 64'(n_strobe - s_str), 64'd256);
    chk("both_st_wr", 64'(n_wr_acc - s_wr), 64'd0);

    // Out-of-range load
    for (int k = 0; k < 256; k++) q_buf.push_back('{addr: 17'(k), data: 16'hFFFF});
    s_rd = n_st_rd; s_oob = n_oob; s_str = n_strobe;
    do_xfer(1'b1, 1'b0, 32'd600);
    chk("oobld_queue_left", 64'(q_buf.size()), 64'd0);
    chk("oobld_strobes", 64'(n_strobe - s_str), 64'd256);
    chk("oobld_st_rd", 64'(n_st_rd - s_rd), 64'd0);
    chk("oobld_pulse", 64'(n_oob - s_oob), 64'd1);

    // Out-of-range save
    s_wr = n_wr_acc; s_oob = n_oob; s_str = n_strobe;
    do_xfer(1'b0, 1'b1, 32'd600);
    chk("oobsv_st_wr", 64'(n_wr_acc - s_wr), 64'd0);
    chk("oobsv_pulse", 64'(n_oob - s_oob), 64'd1);
    chk("oobsv_strobes", 64'(n_strobe - s_str), 64'd0);

    // Reset in the middle of a save to lba 2
    max_stall = 3;
    for (int k = 0; k < 256; k++) smem[2*256 + k] = 16'hC000 + 16'(k);
    for (int k = 0; k < 100; k++) q_st.push_back('{addr: 17'(512 + k), data: ~16'(k)});
    s_wr = n_wr_acc;
    @(negedge clk_sys);
    sd_wr = 1'b1; sd_lba = 32'd2;
    wait_ack(1'b1, 50, "rst_ack_rise");
    sd_wr = 1'b0;
    i = 0;
    while (n_wr_acc < s_wr + 100 && i < 3000) begin
      @(posedge clk_sys);
      i++;
    end
    chk("rst_words_before", 64'(n_wr_acc - s_wr), 64'd100);
    #2 reset_n = 1'b0;
    #1 chk_outputs_zero("rst_outputs");
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("rst_queue_left", 64'(q_st.size()), 64'd0);
    chk("rst_st_wr_total", 64'(n_wr_acc - s_wr), 64'd100);
    bad = 0;
    for (int k = 100; k < 256; k++) if (smem[512 + k] !== 16'hC000 + 16'(k)) bad++;
    chk("rst_untouched_bad", 64'(bad), 64'd0);

    // Load lba 2 after reset: starts at word 0, shows the partial save
    for (int k = 0; k < 256; k++)
      q_buf.push_back('{addr: 17'(k), data: (k < 100) ? ~16'(k) : 16'hC000 + 16'(k)});
    s_str = n_strobe;
    do_xfer(1'b1, 1'b0, 32'd2);
    chk("postrst_queue_left", 64'(q_buf.size()), 64'd0);
    chk("postrst_strobes", 64'(n_strobe - s_str), 64'd256);

    // Back-to-back loads of lba 4 and 5, second request raised in DONE
    max_stall = 1;
    for (int k = 0; k < 256; k++) begin
      smem[4*256 + k] = 16'h0400 + 16'(k);
      smem[5*256 + k] = 16'h0500 + 16'(k);
    end
    push_load(4, 16'h0400);
    push_load(5, 16'h0500);
    s_str = n_strobe;
    @(negedge clk_sys);
    sd_rd = 1'b1; sd_lba = 32'd4;
    wait_ack(1'b1, 50, "b2b_ack_rise1");
    sd_rd = 1'b0;
    wait_ack(1'b0, 5000, "b2b_ack_fall1");
    sd_rd = 1'b1; sd_lba = 32'd5;
    low = 0; i = 0;
    while (!sd_ack && i < 50) begin
      low++;
      @(negedge clk_sys);
      i++;
    end
    sd_rd = 1'b0;
    chk("b2b_ack_gap_ge2", 64'(low >= 2), 64'd1);
    chk("b2b_ack_rise2", 64'(sd_ack), 64'd1);
    wait_ack(1'b0, 5000, "b2b_ack_fall2");
    repeat (2) @(negedge clk_sys);
    chk("b2b_queue_left", 64'(q_buf.size()), 64'd0);
    chk("b2b_strobes", 64'(n_strobe - s_str), 64'd512);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
